// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall bus width,
// stage indices, FSM state encoding and flush-counter helpers.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam int FCNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Flush counter counts down to zero, so a sequence of N cycles loads N-1.
  function automatic logic [FCNT_W-1:0] fcnt_load(input int cycles);
    return FCNT_W'(cycles - 1);
  endfunction

  // With a single flush cycle the redirect strobe coincides with the first flush cycle.
  function automatic logic strobe_on_entry(input int cycles);
    return (cycles == 1) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_watchdog.sv
// Stall watchdog: consecutive-stall run counter with sticky timeout flag, plus a
// free-running total of stalled cycles.
module stall_watchdog
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stalling,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [15:0]      MAX_C   = 16'(MAX_STALL);
  localparam logic [15:0]      TRIP_C  = 16'(MAX_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [15:0] run_cnt_r;

  // Run counter saturates at the limit; the flag is set on the same edge the run reaches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_r     <= 16'd0;
      stall_timeout <= 1'b0;
      stall_cycles  <= {CNT_W{1'b0}};
    end else if (stalling) begin
      if (run_cnt_r < MAX_C) begin
        run_cnt_r <= run_cnt_r + 16'd1;
      end else begin
        run_cnt_r <= run_cnt_r;
      end
      if (run_cnt_r >= TRIP_C) begin
        stall_timeout <= 1'b1;
      end else begin
        stall_timeout <= stall_timeout;
      end
      stall_cycles <= stall_cycles + CNT_ONE;
    end else begin
      run_cnt_r     <= 16'd0;
      stall_timeout <= stall_timeout;
      stall_cycles  <= stall_cycles;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: derives per-stage stall and bubble vectors and
// sequences the exception flush with a PC redirect strobe.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int STAGES       = STALL_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 64,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              except_req,
  input  logic [31:0]       except_pc,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              new_pc_valid,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [FCNT_W-1:0] FCNT_LOAD = fcnt_load(FLUSH_CYCLES);
  localparam logic              NV_FIRST  = strobe_on_entry(FLUSH_CYCLES);

  state_e              state_r;
  logic [FCNT_W-1:0]   fcnt_r;
  logic [STAGES-1:0]   stall_s;
  logic [STAGES-1:0]   bubble_s;
  logic                acc_s;

  // Stall at stage k freezes every earlier stage; flush and exceptions suppress all stalls.
  always_comb begin
    stall_s = {STAGES{1'b0}};
    acc_s   = 1'b0;
    if (rst || (state_r != ST_IDLE) || except_req) begin
      stall_s = {STAGES{1'b0}};
    end else begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        acc_s      = acc_s | stallreq[k];
        stall_s[k] = acc_s;
      end
    end
  end

  // A stage loads a NOP when its upstream neighbour holds but it does not.
  always_comb begin
    bubble_s = {STAGES{1'b0}};
    for (int k = 1; k < STAGES; k++) begin
      bubble_s[k] = stall_s[k-1] & ~stall_s[k];
    end
  end

  assign stall  = stall_s;
  assign bubble = bubble_s;

  // Exception flush sequencer with registered flush, redirect target and strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      fcnt_r       <= {FCNT_W{1'b0}};
      flush        <= 1'b0;
      new_pc       <= 32'h0000_0000;
      new_pc_valid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (except_req) begin
            state_r      <= ST_FLUSH;
            fcnt_r       <= FCNT_LOAD;
            flush        <= 1'b1;
            new_pc       <= except_pc;
            new_pc_valid <= NV_FIRST;
          end else begin
            flush        <= 1'b0;
            new_pc_valid <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // Exceptions arriving here are dropped, not queued.
          if (fcnt_r == {FCNT_W{1'b0}}) begin
            state_r      <= ST_IDLE;
            flush        <= 1'b0;
            new_pc_valid <= 1'b0;
          end else begin
            fcnt_r       <= fcnt_r - 4'd1;
            flush        <= 1'b1;
            new_pc_valid <= (fcnt_r == 4'd1) ? 1'b1 : 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          flush        <= 1'b0;
          new_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  stall_watchdog #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stalling      (stall_s[STG_PC]),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

endmodule
